// File: rtl/md_seq_ctrl_pkg.sv
// Shared encodings for the multiply/divide sequencer.
//   md_op_e    : MD opcode as presented by the execute stage
//   md_state_e : sequencer FSM states
package md_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } md_state_e;

endpackage

// File: rtl/md_seq_ctrl_iter_core.sv
// One iteration of the multiply/divide datapath on the {acc,q} register pair.
//   is_div : 1 = restoring-divide step, 0 = shift-add multiply step
//   acc_i  : upper half (partial product / partial remainder)
//   q_i    : lower half (multiplier bits / dividend-then-quotient bits)
//   opb_i  : multiplicand (multiply) or divisor (divide)
//   acc_o, q_o : register pair after this step
module md_iter_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] opb_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] diff;

  always_comb begin
    sum   = {1'b0, acc_i} + {1'b0, opb_i};
    rem   = {acc_i, q_i[WIDTH-1]};
    // Only used when rem >= divisor, so the true difference fits in WIDTH bits.
    diff  = rem[WIDTH-1:0] - opb_i;
    acc_o = acc_i;
    q_o   = q_i;
    if (is_div) begin
      if (rem >= {1'b0, opb_i}) begin
        acc_o = diff;
        q_o   = {q_i[WIDTH-2:0], 1'b1};
      end else begin
        acc_o = rem[WIDTH-1:0];
        q_o   = {q_i[WIDTH-2:0], 1'b0};
      end
    end else begin
      // Carry out of the add shifts into the top of acc.
      if (q_i[0]) begin
        {acc_o, q_o} = {sum, q_i[WIDTH-1:1]};
      end else begin
        {acc_o, q_o} = {1'b0, acc_i, q_i[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: rtl/md_seq_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer for the MIPS execute stage.
//   clk, resetn     : clock (rising edge), asynchronous active-low reset
//   md_valid, md_op : op request from execute (00 MULT,01 MULTU,10 DIV,11 DIVU)
//   md_src_a/b      : rs / rt operands, latched on accept
//   md_flush        : cancel any in-flight op
//   md_ready        : an op can be accepted this cycle
//   md_busy         : pipeline stall while iterating
//   md_double_en    : one-cycle HI/LO write strobe
//   md_result       : {HI,LO}, valid while md_double_en is high, else 0
module md_seq_ctrl
  import md_seq_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               md_valid,
  input  logic [1:0]         md_op,
  input  logic [WIDTH-1:0]   md_src_a,
  input  logic [WIDTH-1:0]   md_src_b,
  input  logic               md_flush,
  output logic               md_ready,
  output logic               md_busy,
  output logic               md_double_en,
  output logic [2*WIDTH-1:0] md_result
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  md_state_e        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             is_div_q, is_div_d;
  logic             signed_q, signed_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;

  logic [WIDTH-1:0] core_acc, core_q;

  md_op_e           op;
  logic             op_div, op_signed, accept;
  logic [WIDTH-1:0] mag_a, mag_b;

  md_iter_core #(.WIDTH(WIDTH)) u_core (
    .is_div (is_div_q),
    .acc_i  (acc_q),
    .q_i    (q_q),
    .opb_i  (opb_q),
    .acc_o  (core_acc),
    .q_o    (core_q)
  );

  always_comb begin
    op        = md_op_e'(md_op);
    op_div    = (op == MD_DIV) || (op == MD_DIVU);
    op_signed = (op == MD_MULT) || (op == MD_DIV);
    // Most-negative value maps to itself, read as unsigned.
    mag_a     = (op_signed && md_src_a[WIDTH-1]) ? -md_src_a : md_src_a;
    mag_b     = (op_signed && md_src_b[WIDTH-1]) ? -md_src_b : md_src_b;
    accept    = md_valid && !md_flush && (state_q != CALC);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    q_d      = q_q;
    opb_d    = opb_q;
    is_div_d = is_div_q;
    signed_d = signed_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;

    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept) begin
          is_div_d = op_div;
          signed_d = op_signed;
          sign_a_d = op_signed && md_src_a[WIDTH-1];
          sign_b_d = op_signed && md_src_b[WIDTH-1];
          cnt_d    = '0;
          acc_d    = '0;
          state_d  = CALC;
          if (op_div) begin
            q_d   = mag_a;
            opb_d = mag_b;
            if (md_src_b == '0) begin
              // Divide-by-zero: preload the fixed result and skip iteration.
              state_d  = DONE;
              acc_d    = md_src_a;
              q_d      = '1;
              signed_d = 1'b0;
              sign_a_d = 1'b0;
              sign_b_d = 1'b0;
            end
          end else begin
            q_d   = mag_b;
            opb_d = mag_a;
          end
        end
      end
      CALC: begin
        acc_d = core_acc;
        q_d   = core_q;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (md_flush) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      q_q      <= '0;
      opb_q    <= '0;
      is_div_q <= 1'b0;
      signed_q <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      q_q      <= q_d;
      opb_q    <= opb_d;
      is_div_q <= is_div_d;
      signed_q <= signed_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
    end
  end

  logic [2*WIDTH-1:0] prod, mul_res;
  logic [WIDTH-1:0]   quo, rem;
  logic               neg;

  always_comb begin
    prod    = {acc_q, q_q};
    neg     = signed_q && (sign_a_q ^ sign_b_q);
    mul_res = neg ? -prod : prod;
    quo     = neg ? -q_q : q_q;
    rem     = (signed_q && sign_a_q) ? -acc_q : acc_q;

    md_ready     = (state_q != CALC);
    md_busy      = (state_q == CALC);
    md_double_en = (state_q == DONE);
    md_result    = '0;
    if (state_q == DONE) begin
      md_result = is_div_q ? {rem, quo} : mul_res;
    end
  end

endmodule
